tqvp_dlmiles_i2c_byte_engine: RTL

//  I2C master bit/byte sequencer: executes START, STOP, WRITE-byte and READ-byte commands from the

---
 rtl/tqvp_dlmiles_i2c_byte_engine.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/tqvp_dlmiles_i2c_byte_engine.sv
// I2C master bit/byte sequencer: START, STOP, WRITE and READ commands built from
// four-phase bus steps timed by a quarter-period ticker, with stretch timeout and arbitration.
//
// state   | meaning
// S_IDLE  | waiting for a command, bus lines hold their last level
// S_START | four-phase START / repeated START
// S_STOP  | four-phase STOP, ends with both lines released
// S_BIT   | nine four-phase bit slots of a WRITE or READ byte
module tqvp_dlmiles_i2c_byte_engine #(
   parameter int DIV_WIDTH     = 8,
   parameter int STRETCH_TICKS = 1024
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [DIV_WIDTH-1:0] clk_div,
   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic [2:0]           cmd_op,
   input  logic [7:0]           cmd_data,
   input  logic                 cmd_nack,
   output logic                 rsp_valid,
   output logic [1:0]           rsp_status,
   output logic [7:0]           rsp_data,
   output logic                 busy,
   input  logic                 scl_i,
   input  logic                 sda_i,
   output logic                 scl_o,
   output logic                 scl_oe,
   output logic                 sda_o,
   output logic                 sda_oe
);

   localparam int WW = $clog2(STRETCH_TICKS + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_START = 2'd1;
   localparam logic [1:0] S_STOP  = 2'd2;
   localparam logic [1:0] S_BIT   = 2'd3;

   localparam logic [2:0] OP_START = 3'b001;
   localparam logic [2:0] OP_STOP  = 3'b010;
   localparam logic [2:0] OP_WRITE = 3'b011;
   localparam logic [2:0] OP_READ  = 3'b100;

   logic [1:0]           state;
   logic [1:0]           phase;
   logic [3:0]           bit_idx;
   logic                 is_read;
   logic                 nack_q;
   logic                 ack_q;
   logic [7:0]           tx;
   logic [7:0]           rx;
   logic [DIV_WIDTH-1:0] div_q;
   logic [DIV_WIDTH-1:0] cnt;
   logic [DIV_WIDTH-1:0] scnt;
   logic [WW-1:0]        wcnt;

   logic       stretched;
   logic       tick;
   logic       done_now;
   logic       arb_now;
   logic       timeout_now;
   logic       next_rel;
   logic [3:0] nb;

   assign cmd_ready = (state == S_IDLE) && !rsp_valid;
   assign busy      = !cmd_ready;
   assign scl_o     = !scl_oe;
   assign sda_o     = !sda_oe;

   // SCL is only ours to wait on while we have released it
   assign stretched   = (state != S_IDLE) && !scl_oe && !scl_i;
   assign tick        = (state != S_IDLE) && (cnt == '0) && !stretched;
   assign done_now    = tick && (phase == 2'd3) && ((state != S_BIT) || (bit_idx == 4'd8));
   assign arb_now     = tick && (state == S_BIT) && (phase == 2'd2) && !is_read &&
                        !bit_idx[3] && !sda_oe && !sda_i;
   assign timeout_now = stretched && (scnt == '0) && (wcnt == WW'(STRETCH_TICKS - 1));

   // SDA release level for the next bit slot: data bits, then ACK slot
   assign nb       = bit_idx + 4'd1;
   assign next_rel = (nb == 4'd8) ? (is_read ? nack_q : 1'b1) : (is_read | tx[~nb[2:0]]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         phase      <= 2'd0;
         bit_idx    <= 4'd0;
         is_read    <= 1'b0;
         nack_q     <= 1'b0;
         ack_q      <= 1'b0;
         tx         <= 8'h00;
         rx         <= 8'h00;
         div_q      <= '0;
         cnt        <= '0;
         scnt       <= '0;
         wcnt       <= '0;
         scl_oe     <= 1'b0;
         sda_oe     <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_status <= 2'b00;
         rsp_data   <= 8'h00;
      end else begin
         rsp_valid <= 1'b0;
         if (state == S_IDLE) begin
            if (cmd_valid && cmd_ready) begin
               div_q   <= clk_div;
               cnt     <= clk_div;
               scnt    <= clk_div;
               wcnt    <= '0;
               phase   <= 2'd0;
               bit_idx <= 4'd0;
               rx      <= 8'h00;
               ack_q   <= 1'b0;
               tx      <= cmd_data;
               nack_q  <= cmd_nack;
               is_read <= (cmd_op == OP_READ);
               case (cmd_op)
                  OP_START: begin
                     state  <= S_START;
                     sda_oe <= 1'b0;
                  end
                  OP_STOP: begin
                     state  <= S_STOP;
                     sda_oe <= 1'b1;
                  end
                  OP_WRITE: begin
                     state  <= S_BIT;
                     scl_oe <= 1'b1;
                     sda_oe <= !cmd_data[7];
                  end
                  OP_READ: begin
                     state  <= S_BIT;
                     scl_oe <= 1'b1;
                     sda_oe <= 1'b0;
                  end
                  default: begin
                     rsp_valid  <= 1'b1;
                     rsp_status <= 2'b00;
                     rsp_data   <= 8'h00;
                  end
               endcase
            end
         end else if (timeout_now || arb_now) begin
            state      <= S_IDLE;
            scl_oe     <= 1'b0;
            sda_oe     <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_status <= timeout_now ? 2'b11 : 2'b10;
            rsp_data   <= rx;
         end else if (stretched) begin
            cnt <= div_q;
            if (scnt != '0) begin
               scnt <= scnt - 1'b1;
            end else begin
               scnt <= div_q;
               wcnt <= wcnt + 1'b1;
            end
         end else if (!tick) begin
            cnt  <= cnt - 1'b1;
            scnt <= div_q;
         end else begin
            cnt   <= div_q;
            scnt  <= div_q;
            wcnt  <= '0;
            phase <= phase + 2'd1;
            if (done_now) begin
               state      <= S_IDLE;
               rsp_valid  <= 1'b1;
               rsp_status <= {1'b0, ack_q};
               rsp_data   <= rx;
               if (state == S_BIT) scl_oe <= 1'b1;
            end else begin
               case (state)
                  S_START: begin
                     case (phase)
                        2'd0:    scl_oe <= 1'b0;
                        2'd1:    sda_oe <= 1'b1;
                        2'd2:    scl_oe <= 1'b1;
                        default: ;
                     endcase
                  end
                  S_STOP: begin
                     case (phase)
                        2'd0:    scl_oe <= 1'b0;
                        2'd1:    sda_oe <= 1'b0;
                        default: ;
                     endcase
                  end
                  default: begin
                     case (phase)
                        2'd1: scl_oe <= 1'b0;
                        2'd2: begin
                           if (bit_idx[3]) ack_q <= sda_i & !is_read;
                           else            rx[~bit_idx[2:0]] <= sda_i;
                        end
                        2'd3: begin
                           bit_idx <= nb;
                           scl_oe  <= 1'b1;
                           sda_oe  <= !next_rel;
                        end
                        default: ;
                     endcase
                  end
               endcase
            end
         end
      end
   end

endmodule
